// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared pipeline-stage constants: the stage occupancy state encoding and a
// helper that maps a state onto the held-entry count.
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

  // Encodings are fixed so that state and occupancy share the same numbers.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int unsigned MAX_ENTRIES = 2;

  // Number of entries held in a given state (0..MAX_ENTRIES).
  function automatic logic [1:0] state_occupancy(input stage_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_EMPTY: n = 2'd0;
      ST_ONE:   n = 2'd1;
      ST_TWO:   n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline entry: a {pc, ir, payload} register with synchronous load and
// clear. Clear wins over load, so a flushed entry always reads as zero.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset, zeroes the entry
//   load          capture pc_next/ir_next/payload_next at the next edge
//   clear         zero the entry at the next edge (priority over load)
//   pc_next, ir_next, payload_next   value to capture
//   pc, ir, payload                  held value
// ---------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int unsigned PC_BITS      = 32,
  parameter int unsigned IR_BITS      = 32,
  parameter int unsigned PAYLOAD_BITS = 160
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic [PC_BITS-1:0]      pc_next,
  input  logic [IR_BITS-1:0]      ir_next,
  input  logic [PAYLOAD_BITS-1:0] payload_next,
  output logic [PC_BITS-1:0]      pc,
  output logic [IR_BITS-1:0]      ir,
  output logic [PAYLOAD_BITS-1:0] payload
);

  // NOTE: the entry data is reset and cleared on purpose, not just the
  // valid state: the stage drives the head entry straight onto out_*, and a
  // bubble must read as all-zero rather than stale data.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      payload <= '0;
    end else if (clear) begin
      pc      <= '0;
      ir      <= '0;
      payload <= '0;
    end else if (load) begin
      pc      <= pc_next;
      ir      <= ir_next;
      payload <= payload_next;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Generic valid/ready pipeline stage register carrying {pc, ir, payload}.
// Existing stage registers map onto it by packing their control/data fields
// into payload. With SKID=1 it is a two-entry skid buffer whose in_ready is a
// flop (no combinational out_ready -> in_ready path); with SKID=0 it is a
// single entry with a combinational in_ready. Latency is one cycle and
// throughput one per cycle in both modes. out_* read zero whenever
// out_valid=0.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   flush                     discard all held entries at the next edge
//   in_valid / in_ready       upstream handshake
//   in_pc, in_ir, in_payload  offered instruction
//   out_valid / out_ready     downstream handshake
//   out_pc, out_ir, out_payload  head entry (zero when out_valid=0)
//   occupancy                 held entries, 0..2
//   stall_cnt                 saturating count of out_valid && !out_ready edges
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned PC_BITS      = 32,
  parameter int unsigned IR_BITS      = 32,
  parameter int unsigned PAYLOAD_BITS = 160,
  parameter int unsigned SKID         = 1,
  parameter int unsigned CNT_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PC_BITS-1:0]      in_pc,
  input  logic [IR_BITS-1:0]      in_ir,
  input  logic [PAYLOAD_BITS-1:0] in_payload,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_BITS-1:0]      out_pc,
  output logic [IR_BITS-1:0]      out_ir,
  output logic [PAYLOAD_BITS-1:0] out_payload,
  output logic [1:0]              occupancy,
  output logic [CNT_BITS-1:0]     stall_cnt
);

  localparam bit SKID_EN = (SKID != 0);

  stage_state_e state, state_next;

  logic accept;
  logic fire;

  logic head_load, head_clear, head_from_skid;
  logic skid_load, skid_clear;

  logic [PC_BITS-1:0]      head_pc_next;
  logic [IR_BITS-1:0]      head_ir_next;
  logic [PAYLOAD_BITS-1:0] head_payload_next;

  logic [PC_BITS-1:0]      skid_pc;
  logic [IR_BITS-1:0]      skid_ir;
  logic [PAYLOAD_BITS-1:0] skid_payload;

  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign occupancy = state_occupancy(state);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next state and entry control
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path through
  // the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next     = state;
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;

    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_ONE;
          head_load  = 1'b1;
        end
      end

      ST_ONE: begin
        if (accept && fire) begin
          // Head leaves and is replaced by the input in the same edge.
          head_load = 1'b1;
        end else if (accept) begin
          // Only reachable with SKID=1: with SKID=0 in_ready in ONE equals
          // out_ready, so an accept always coincides with a fire.
          if (SKID_EN) begin
            state_next = ST_TWO;
            skid_load  = 1'b1;
          end
        end else if (fire) begin
          state_next = ST_EMPTY;
          head_clear = 1'b1;
        end
      end

      ST_TWO: begin
        // in_ready is 0 here, so only a fire can move the state.
        if (fire) begin
          state_next     = ST_ONE;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
      end

      default: begin
        state_next = ST_EMPTY;
        head_clear = 1'b1;
        skid_clear = 1'b1;
      end
    endcase

    // Flush overrides any accept/fire this cycle. A handshake that still
    // happens upstream or downstream is simply dropped from the stage.
    if (flush) begin
      state_next     = ST_EMPTY;
      head_load      = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      head_clear     = 1'b1;
      skid_clear     = 1'b1;
    end
  end

  // Head is filled from the input, or from the skid entry when it is promoted.
  always_comb begin
    head_pc_next      = in_pc;
    head_ir_next      = in_ir;
    head_payload_next = in_payload;
    if (head_from_skid) begin
      head_pc_next      = skid_pc;
      head_ir_next      = skid_ir;
      head_payload_next = skid_payload;
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  pipe_entry_reg #(
    .PC_BITS      (PC_BITS),
    .IR_BITS      (IR_BITS),
    .PAYLOAD_BITS (PAYLOAD_BITS)
  ) u_head (
    .clk          (clk),
    .rst          (rst),
    .load         (head_load),
    .clear        (head_clear),
    .pc_next      (head_pc_next),
    .ir_next      (head_ir_next),
    .payload_next (head_payload_next),
    .pc           (out_pc),
    .ir           (out_ir),
    .payload      (out_payload)
  );

  pipe_entry_reg #(
    .PC_BITS      (PC_BITS),
    .IR_BITS      (IR_BITS),
    .PAYLOAD_BITS (PAYLOAD_BITS)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .clear        (skid_clear),
    .pc_next      (in_pc),
    .ir_next      (in_ir),
    .payload_next (in_payload),
    .pc           (skid_pc),
    .ir           (skid_ir),
    .payload      (skid_payload)
  );

  // -------------------------------------------------------------------------
  // Upstream ready
  // -------------------------------------------------------------------------
  if (SKID_EN) begin : g_skid_ready
    // Registered from the next state so in_ready == (state != ST_TWO) at all
    // times, and out_ready never reaches in_ready combinationally.
    logic ready_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ready_q <= 1'b1;
      else     ready_q <= (state_next != ST_TWO);
    end

    assign in_ready = ready_q;
  end else begin : g_single_ready
    assign in_ready = (state == ST_EMPTY) || out_ready;
  end

  // -------------------------------------------------------------------------
  // Back-pressure counter: saturating, cleared only by reset
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_BITS{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Directed bench for pipe_stage_reg. Instance dut_a uses SKID=1 with a 4-bit
// stall counter; instance dut_b uses SKID=0 with the default counter width.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int PCW = 32;
  localparam int IRW = 32;
  localparam int PLW = 160;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // dut_a: SKID=1, CNT_BITS=4
  logic           a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [PCW-1:0] a_in_pc, a_out_pc;
  logic [IRW-1:0] a_in_ir, a_out_ir;
  logic [PLW-1:0] a_in_payload, a_out_payload;
  logic [1:0]     a_occupancy;
  logic [3:0]     a_stall_cnt;

  // dut_b: SKID=0, CNT_BITS=16
  logic           b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [PCW-1:0] b_in_pc, b_out_pc;
  logic [IRW-1:0] b_in_ir, b_out_ir;
  logic [PLW-1:0] b_in_payload, b_out_payload;
  logic [1:0]     b_occupancy;
  logic [15:0]    b_stall_cnt;

  pipe_stage_reg #(
    .PC_BITS(PCW), .IR_BITS(IRW), .PAYLOAD_BITS(PLW), .SKID(1), .CNT_BITS(4)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_pc(a_in_pc), .in_ir(a_in_ir), .in_payload(a_in_payload),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_ir(a_out_ir), .out_payload(a_out_payload),
    .occupancy(a_occupancy), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_reg #(
    .PC_BITS(PCW), .IR_BITS(IRW), .PAYLOAD_BITS(PLW), .SKID(0), .CNT_BITS(16)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_ir(b_in_ir), .in_payload(b_in_payload),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_ir(b_out_ir), .out_payload(b_out_payload),
    .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
  );

  function automatic logic [IRW-1:0] mk_ir(input logic [PCW-1:0] pc);
    return pc ^ 32'h0000_0013;
  endfunction

  function automatic logic [PLW-1:0] mk_payload(input logic [PCW-1:0] pc);
    return {pc, ~pc, pc ^ 32'h5a5a_5a5a, pc + 32'd1, 32'hc0de_0000 | pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [PCW-1:0] pc, input logic rdy, input logic fl);
    a_in_valid   = v;
    a_in_pc      = pc;
    a_in_ir      = mk_ir(pc);
    a_in_payload = mk_payload(pc);
    a_out_ready  = rdy;
    a_flush      = fl;
  endtask

  task automatic drive_b(input logic v, input logic [PCW-1:0] pc, input logic rdy, input logic fl);
    b_in_valid   = v;
    b_in_pc      = pc;
    b_in_ir      = mk_ir(pc);
    b_in_payload = mk_payload(pc);
    b_out_ready  = rdy;
    b_flush      = fl;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b0, '0, 1'b0, 1'b0);
    drive_b(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", a_occupancy); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_stall_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", a_stall_cnt); end
    n_cmp++; if (a_out_pc !== '0 || a_out_ir !== '0 || a_out_payload !== '0) begin n_bad++; $display("FAIL reset_out_zero: got pc %h ir %h want 0", a_out_pc, a_out_ir); end
    n_cmp++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b: got valid %b ready %b want 0/1", b_out_valid, b_in_ready); end
    rst = 1'b0;
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_streaming();
    logic [PCW-1:0] pc;
    for (int i = 0; i < 3; i++) begin
      pc = PCW'(4 * i);
      drive_a(1'b1, pc, 1'b1, 1'b0);
      step();
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_pc !== pc) begin n_bad++; $display("FAIL stream_pc%0d: got valid %b pc %h want 1 %h", i, a_out_valid, a_out_pc, pc); end
      n_cmp++; if (a_occupancy !== 2'd1) begin n_bad++; $display("FAIL stream_occ%0d: got %0d want 1", i, a_occupancy); end
      n_cmp++; if (a_out_ir !== mk_ir(pc) || a_out_payload !== mk_payload(pc)) begin n_bad++; $display("FAIL stream_data%0d: got ir %h want %h", i, a_out_ir, mk_ir(pc)); end
    end
    drive_a(1'b0, '0, 1'b1, 1'b0);
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0) begin n_bad++; $display("FAIL stream_drain: got valid %b occ %0d want 0 0", a_out_valid, a_occupancy); end
    n_cmp++; if (a_out_pc !== '0 || a_out_payload !== '0) begin n_bad++; $display("FAIL stream_bubble: got pc %h want 0", a_out_pc); end
    n_cmp++; if (a_stall_cnt !== 4'd0) begin n_bad++; $display("FAIL stream_stall: got %0d want 0", a_stall_cnt); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_skid();
    drive_a(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    n_cmp++; if (a_occupancy !== 2'd1 || a_out_pc !== 32'h10 || a_in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_one: got occ %0d pc %h rdy %b want 1 10 1", a_occupancy, a_out_pc, a_in_ready); end
    drive_a(1'b1, 32'h14, 1'b0, 1'b0);
    step();
    n_cmp++; if (a_occupancy !== 2'd2) begin n_bad++; $display("FAIL skid_occ2: got %0d want 2", a_occupancy); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_in_ready0: got %b want 0", a_in_ready); end
    n_cmp++; if (a_out_pc !== 32'h10) begin n_bad++; $display("FAIL skid_head: got %h want 10", a_out_pc); end
    n_cmp++; if (a_stall_cnt !== 4'd1) begin n_bad++; $display("FAIL skid_stall: got %0d want 1", a_stall_cnt); end
    // in_ready must not follow out_ready combinationally in TWO.
    drive_a(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_bad++; $display("FAIL skid_ready_comb: got %b want 0", a_in_ready); end
    step();
    n_cmp++; if (a_occupancy !== 2'd1 || a_out_pc !== 32'h14 || a_out_ir !== mk_ir(32'h14)) begin n_bad++; $display("FAIL skid_promote: got occ %0d pc %h want 1 14", a_occupancy, a_out_pc); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_ready_back: got %b want 1", a_in_ready); end
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0) begin n_bad++; $display("FAIL skid_drain: got valid %b occ %0d want 0 0", a_out_valid, a_occupancy); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_flush();
    drive_a(1'b1, 32'h18, 1'b0, 1'b0);
    step();
    drive_a(1'b1, 32'h1c, 1'b0, 1'b0);
    step();
    n_cmp++; if (a_occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_setup: got %0d want 2", a_occupancy); end
    drive_a(1'b1, 32'h20, 1'b0, 1'b1);
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0) begin n_bad++; $display("FAIL flush_empty: got valid %b occ %0d want 0 0", a_out_valid, a_occupancy); end
    n_cmp++; if (a_out_pc !== '0 || a_out_ir !== '0 || a_out_payload !== '0) begin n_bad++; $display("FAIL flush_zero: got pc %h ir %h want 0", a_out_pc, a_out_ir); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_stall_cnt !== 4'd3) begin n_bad++; $display("FAIL flush_stall_kept: got %0d want 3", a_stall_cnt); end
    drive_a(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (a_out_valid !== 1'b0 || a_out_pc !== '0) begin n_bad++; $display("FAIL flush_no_reappear%0d: got valid %b pc %h want 0 0", i, a_out_valid, a_out_pc); end
    end
    // Flush in ONE while in_ready=1: input is handshaken and dropped, and the
    // concurrent fire is consumed downstream.
    drive_a(1'b1, 32'h24, 1'b0, 1'b0);
    step();
    drive_a(1'b1, 32'h28, 1'b1, 1'b1);
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0 || a_out_pc !== '0) begin n_bad++; $display("FAIL flush_accept_drop: got valid %b occ %0d pc %h want 0 0 0", a_out_valid, a_occupancy, a_out_pc); end
    drive_a(1'b0, '0, 1'b1, 1'b0);
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_stall_cnt !== 4'd3) begin n_bad++; $display("FAIL flush_after: got valid %b stall %0d want 0 3", a_out_valid, a_stall_cnt); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_saturation();
    int exp_cnt;
    drive_a(1'b1, 32'h40, 1'b0, 1'b0);
    step();
    drive_a(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_cnt = (3 + i > 15) ? 15 : 3 + i;
      n_cmp++; if (a_stall_cnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL sat_cycle%0d: got %0d want %0d", i, a_stall_cnt, exp_cnt); end
    end
    n_cmp++; if (a_out_pc !== 32'h40 || a_occupancy !== 2'd1) begin n_bad++; $display("FAIL sat_hold: got pc %h occ %0d want 40 1", a_out_pc, a_occupancy); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_async_reset();
    drive_a(1'b1, 32'h44, 1'b0, 1'b0);
    step();
    n_cmp++; if (a_occupancy !== 2'd2 || a_in_ready !== 1'b0 || a_stall_cnt !== 4'd15) begin n_bad++; $display("FAIL areset_setup: got occ %0d rdy %b stall %0d want 2 0 15", a_occupancy, a_in_ready, a_stall_cnt); end
    drive_a(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_stall_cnt !== 4'd0) begin n_bad++; $display("FAIL areset_stall: got %0d want 0", a_stall_cnt); end
    n_cmp++; if (a_occupancy !== 2'd0 || a_out_pc !== '0) begin n_bad++; $display("FAIL areset_entries: got occ %0d pc %h want 0 0", a_occupancy, a_out_pc); end
    #1 rst = 1'b0;
    step();
    n_cmp++; if (a_out_valid !== 1'b0 || a_occupancy !== 2'd0) begin n_bad++; $display("FAIL areset_after: got valid %b occ %0d want 0 0", a_out_valid, a_occupancy); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_entry();
    drive_b(1'b1, 32'h30, 1'b1, 1'b0);
    step();
    n_cmp++; if (b_out_pc !== 32'h30 || b_occupancy !== 2'd1) begin n_bad++; $display("FAIL single_one: got pc %h occ %0d want 30 1", b_out_pc, b_occupancy); end
    drive_b(1'b1, 32'h34, 1'b0, 1'b0);
    #1;
    n_cmp++; if (b_in_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_low: got %b want 0", b_in_ready); end
    b_out_ready = 1'b1;
    #1;
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_comb: got %b want 1", b_in_ready); end
    step();
    n_cmp++; if (b_out_pc !== 32'h34 || b_occupancy !== 2'd1 || b_out_payload !== mk_payload(32'h34)) begin n_bad++; $display("FAIL single_replace: got pc %h occ %0d want 34 1", b_out_pc, b_occupancy); end
    drive_b(1'b1, 32'h38, 1'b0, 1'b0);
    step();
    n_cmp++; if (b_out_pc !== 32'h34 || b_occupancy !== 2'd1) begin n_bad++; $display("FAIL single_no_two: got pc %h occ %0d want 34 1", b_out_pc, b_occupancy); end
    n_cmp++; if (b_stall_cnt !== 16'd1) begin n_bad++; $display("FAIL single_stall: got %0d want 1", b_stall_cnt); end
    drive_b(1'b0, '0, 1'b1, 1'b0);
    step();
    n_cmp++; if (b_out_valid !== 1'b0 || b_out_pc !== '0) begin n_bad++; $display("FAIL single_drain: got valid %b pc %h want 0 0", b_out_valid, b_out_pc); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_saturation();
    test_async_reset();
    test_single_entry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter PC_BITS, default 32, meaning program-counter field width.
REQ-002 The block SHALL have parameter IR_BITS, default 32, meaning instruction field width.
REQ-003 The block SHALL have parameter PAYLOAD_BITS, default 160, meaning packed control/data bundle width.
REQ-004 The block SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered in_ready, 0 = single entry.
REQ-005 The block SHALL have parameter CNT_BITS, default 16, meaning back-pressure counter width.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all flops on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-008 The block SHALL have port flush, input, 1 bit, meaning discard all held entries.
REQ-009 The block SHALL have port in_valid, input, 1 bit, meaning upstream offers an instruction.
REQ-010 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts this cycle.
REQ-011 The block SHALL have ports in_pc, in_ir and in_payload, inputs of PC_BITS, IR_BITS and PAYLOAD_BITS, meaning the offered instruction.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning head entry present.
REQ-013 The block SHALL have port out_ready, input, 1 bit, meaning downstream consumes this cycle.
REQ-014 The block SHALL have ports out_pc, out_ir and out_payload, outputs of PC_BITS, IR_BITS and PAYLOAD_BITS, meaning the head entry.
REQ-015 The block SHALL have port occupancy, output, 2 bits, meaning the count of held entries (0..2).
REQ-016 The block SHALL have port stall_cnt, output, CNT_BITS, meaning saturating back-pressure cycle count.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready at a rising edge; fire SHALL occur when out_valid && out_ready at a rising edge.
REQ-018 States SHALL be EMPTY, ONE and TWO; TWO SHALL be reachable only when SKID=1.
REQ-019 From EMPTY, accept SHALL go to ONE.
REQ-020 From ONE, accept without fire SHALL go to TWO (SKID=1); fire without accept SHALL go to EMPTY; accept with fire SHALL stay in ONE with the head replaced by the input.
REQ-021 From TWO, fire SHALL go to ONE with the skid entry promoted to head, and in_ready SHALL be 0 in TWO.
REQ-022 With SKID=1, in_ready SHALL be a flop output equal to (state != TWO), with no combinational path from out_ready.
REQ-023 With SKID=0, in_ready SHALL equal (state == EMPTY) || out_ready, combinationally.
REQ-024 Latency SHALL be 1 cycle: an instruction accepted at edge N is on out_* with out_valid=1 after edge N, and sustained throughput SHALL be 1 per cycle.
REQ-025 Order SHALL be strictly FIFO, with no entry duplicated or dropped except by flush.
REQ-026 out_pc, out_ir and out_payload SHALL be all-zero whenever out_valid=0, giving bubble semantics.
REQ-027 flush SHALL force EMPTY at the next edge, override accept and fire that cycle, and zero both entries.
REQ-028 An input offered in a flush cycle SHALL be handshaken if in_ready=1 and then discarded.
REQ-029 A fire coinciding with flush SHALL still count as consumed downstream.
REQ-030 occupancy SHALL be 0/1/2 for EMPTY/ONE/TWO.
REQ-031 stall_cnt SHALL increment by 1 on each edge where out_valid && !out_ready, saturate at all-ones, and be cleared only by rst.

Reset
REQ-032 While rst=1, state SHALL be EMPTY and both entries zero.
REQ-033 While rst=1, out_valid=0, occupancy=0, stall_cnt=0 and out_* zero.
REQ-034 While rst=1, in_ready SHALL be 1 (SKID=1 flop reset value 1).
REQ-035 Reset asserted mid-transfer SHALL discard held entries immediately, without waiting for clk.

Structure
REQ-036 State encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) SHALL live in the shared pipeline constants package/header.
REQ-037 One sub-module pipe_entry_reg SHALL hold a {pc, ir, payload} entry with load and clear inputs, instantiated twice (head, skid).
REQ-038 Existing stage registers SHALL be replaceable by packing their control/data fields into payload.

Verification
REQ-039 The bench SHALL check streaming: out_ready=1, accept pc 0x0, 0x4, 0x8 on consecutive edges -> out_pc shows 0x0, 0x4, 0x8 one cycle later each, with occupancy staying 1.
REQ-040 The bench SHALL check skid: SKID=1, ONE holding 0x10, out_ready=0, accept 0x14 -> occupancy=2 and in_ready=0 next cycle; then out_ready=1 -> 0x10 then 0x14 are delivered.
REQ-041 The bench SHALL check flush: occupancy=2 plus flush with in_valid=1 pc 0x20 -> next cycle out_valid=0, out_* = 0, occupancy=0, and 0x20 never appears.
REQ-042 The bench SHALL check saturation: CNT_BITS=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds there.
REQ-043 The bench SHALL check asynchronous reset: rst pulsed between edges with occupancy=2 -> out_valid=0, in_ready=1, stall_cnt=0 before the next edge.
REQ-044 The bench SHALL check SKID=0: ONE holding 0x30 with out_ready=1 and in_valid=1 pc 0x34 -> in_ready=1 in the same cycle and out_pc=0x34 next cycle.
